// File: rtl/ram_ctrl_param.sv
// rtl/ram_ctrl_param.sv - single-port RAM sequencer: pattern fill on write request, paced looping sweep on read request
module ram_ctrl_param #(
    parameter int          DATA_W     = 8,
    parameter int          ADDR_W     = 8,
    parameter int          DEPTH      = 256,
    parameter logic [23:0] CNT_MAX    = 24'd9_999_999,
    parameter int          READ_LOOPS = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_flag,
    input  logic              rd_flag,
    input  logic [1:0]        pat_sel,
    input  logic [DATA_W-1:0] seed,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int                 LOOP_W    = 16;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LOOP_W-1:0]  LOOPS     = LOOP_W'(READ_LOOPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [23:0]         cnt_q, cnt_d;
    logic [LOOP_W-1:0]   loop_q, loop_d;
    logic [1:0]          pat_q, pat_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                start_wr, start_rd;
    logic [ADDR_W-1:0]   addr_inc;
    logic [LOOP_W-1:0]   loop_inc;

    // Address is zero-extended or truncated to the word width before use.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        sel,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] av;
        av = DATA_W'(a);
        case (sel)
            2'd0:    pattern = av;
            2'd1:    pattern = ~av;
            2'd2:    pattern = s;
            default: pattern = s + av;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = '0;
        wr_data_d = '0;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        loop_d    = loop_q;
        pat_d     = pat_q;
        seed_d    = seed_q;
        start_wr  = 1'b0;
        start_rd  = 1'b0;
        addr_inc  = addr_q + ADDR_W'(1);
        loop_inc  = loop_q + LOOP_W'(1);

        case (state_q)
            IDLE: begin
                if (wr_flag) begin
                    start_wr = 1'b1;
                end else if (rd_flag) begin
                    start_rd = 1'b1;
                end
            end
            WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    addr_d    = addr_inc;
                    wr_data_d = pattern(pat_q, seed_q, addr_inc);
                end
            end
            READ: begin
                if (wr_flag) begin
                    start_wr = 1'b1;
                end else if (rd_flag) begin
                    start_rd = 1'b1;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        if (addr_q == LAST_ADDR) begin
                            addr_d = '0;
                            loop_d = loop_inc;
                            // Zero loops means sweep until aborted.
                            if (READ_LOOPS != 0 && loop_inc == LOOPS) begin
                                state_d = IDLE;
                                rd_en_d = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            addr_d = addr_inc;
                        end
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_wr) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            rd_en_d   = 1'b0;
            addr_d    = '0;
            wr_data_d = pattern(pat_sel, seed, '0);
            pat_d     = pat_sel;
            seed_d    = seed;
        end
        if (start_rd) begin
            state_d = READ;
            rd_en_d = 1'b1;
            addr_d  = '0;
            cnt_d   = '0;
            loop_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            loop_q    <= '0;
            pat_q     <= '0;
            seed_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            loop_q    <= loop_d;
            pat_q     <= pat_d;
            seed_q    <= seed_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign rd_en   = rd_en_q;
    assign addr    = addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ram_ctrl_param.sv
// tb/tb_ram_ctrl_param.sv - directed self-checking bench for ram_ctrl_param
module tb_ram_ctrl_param;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       wr_flag = 1'b0;
    logic       rd_flag = 1'b0;
    logic [1:0] pat_sel = 2'd0;
    logic [7:0] seed    = 8'h00;
    logic       wr_en, rd_en, busy, done;
    logic [3:0] addr;
    logic [7:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [16];
    logic [7:0] q;

    ram_ctrl_param #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(16), .CNT_MAX(24'd3), .READ_LOOPS(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_flag(wr_flag), .rd_flag(rd_flag),
        .pat_sel(pat_sel), .seed(seed), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural single-port RAM with registered read data.
    always @(posedge sys_clk) begin
        if (wr_en) mem[addr] <= wr_data;
        if (rd_en) q <= mem[addr];
    end

    task automatic step;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        step;
        step;
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr, wr_data} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0000", {wr_en, rd_en, busy, done, addr, wr_data});
        end
        sys_rst = 1'b0;
        step;
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr, wr_data} !== 16'h0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %h expected 0000", {wr_en, rd_en, busy, done, addr, wr_data});
        end
    endtask

    // Expected word at address i is e0 + es*i (mod 256); poke disturbs seed/pat_sel and pulses rd_flag mid-fill.
    task automatic test_write_fill(input logic [1:0] p, input logic [7:0] s, input logic [7:0] e0,
                                   input logic [7:0] es, input bit both, input bit poke);
        logic [7:0] exp_d;
        pat_sel = p;
        seed    = s;
        wr_flag = 1'b1;
        rd_flag = both;
        step;
        wr_flag = 1'b0;
        rd_flag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_d = 8'(e0 + es * i);
            n_cmp++;
            if ({wr_en, rd_en, busy, done, addr} !== {4'b1010, 4'(i)}) begin
                n_err++;
                $display("FAIL fill_ctrl[%0d]: got %b expected %b", i, {wr_en, rd_en, busy, done, addr}, {4'b1010, 4'(i)});
            end
            n_cmp++;
            if (wr_data !== exp_d) begin
                n_err++;
                $display("FAIL fill_data[%0d]: got %h expected %h", i, wr_data, exp_d);
            end
            if (poke && i == 7) begin
                seed    = ~s;
                pat_sel = 2'd0;
                rd_flag = 1'b1;
            end
            if (poke && i == 8) rd_flag = 1'b0;
            step;
        end
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr, wr_data} !== 16'h1000) begin
            n_err++;
            $display("FAIL fill_done: got %h expected 1000", {wr_en, rd_en, busy, done, addr, wr_data});
        end
        step;
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr, wr_data} !== 16'h0000) begin
            n_err++;
            $display("FAIL fill_idle: got %h expected 0000", {wr_en, rd_en, busy, done, addr, wr_data});
        end
    endtask

    task automatic test_bounded_read(input logic [7:0] e0, input logic [7:0] es);
        int a;
        rd_flag = 1'b1;
        step;
        rd_flag = 1'b0;
        for (int k = 0; k < 128; k++) begin
            a = (k / 4) % 16;
            n_cmp++;
            if ({wr_en, rd_en, busy, done, addr} !== {4'b0110, 4'(a)}) begin
                n_err++;
                $display("FAIL read_ctrl[%0d]: got %b expected %b", k, {wr_en, rd_en, busy, done, addr}, {4'b0110, 4'(a)});
            end
            if (k % 4 == 3) begin
                n_cmp++;
                if (q !== 8'(e0 + es * a)) begin
                    n_err++;
                    $display("FAIL read_q[%0d]: got %h expected %h", k, q, 8'(e0 + es * a));
                end
            end
            step;
        end
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr} !== 8'b0001_0000) begin
            n_err++;
            $display("FAIL read_done: got %b expected 00010000", {wr_en, rd_en, busy, done, addr});
        end
        step;
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr} !== 8'b0000_0000) begin
            n_err++;
            $display("FAIL read_idle: got %b expected 00000000", {wr_en, rd_en, busy, done, addr});
        end
    endtask

    // Write and read requested together at read address 5: write wins, read ends with no done.
    task automatic test_read_abort;
        rd_flag = 1'b1;
        step;
        rd_flag = 1'b0;
        for (int k = 0; k < 21; k++) begin
            n_cmp++;
            if ({wr_en, rd_en, busy, done, addr} !== {4'b0110, 4'(k / 4)}) begin
                n_err++;
                $display("FAIL abort_pre[%0d]: got %b expected %b", k, {wr_en, rd_en, busy, done, addr}, {4'b0110, 4'(k / 4)});
            end
            if (k < 20) step;
        end
        pat_sel = 2'd2;
        seed    = 8'h3C;
        wr_flag = 1'b1;
        rd_flag = 1'b1;
        step;
        wr_flag = 1'b0;
        rd_flag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({wr_en, rd_en, busy, done, addr, wr_data} !== {4'b1010, 4'(i), 8'h3C}) begin
                n_err++;
                $display("FAIL abort_fill[%0d]: got %h expected %h", i, {wr_en, rd_en, busy, done, addr, wr_data}, {4'b1010, 4'(i), 8'h3C});
            end
            step;
        end
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr, wr_data} !== 16'h1000) begin
            n_err++;
            $display("FAIL abort_fill_done: got %h expected 1000", {wr_en, rd_en, busy, done, addr, wr_data});
        end
        step;
    endtask

    // Re-request at read address 9: sweep restarts at 0 with the loop count cleared.
    task automatic test_restart(input logic [7:0] qv);
        rd_flag = 1'b1;
        step;
        rd_flag = 1'b0;
        for (int k = 0; k < 37; k++) begin
            n_cmp++;
            if ({wr_en, rd_en, busy, done, addr} !== {4'b0110, 4'(k / 4)}) begin
                n_err++;
                $display("FAIL restart_pre[%0d]: got %b expected %b", k, {wr_en, rd_en, busy, done, addr}, {4'b0110, 4'(k / 4)});
            end
            if (k < 36) step;
        end
        rd_flag = 1'b1;
        step;
        rd_flag = 1'b0;
        for (int k = 0; k < 128; k++) begin
            n_cmp++;
            if ({wr_en, rd_en, busy, done, addr} !== {4'b0110, 4'((k / 4) % 16)}) begin
                n_err++;
                $display("FAIL restart_ctrl[%0d]: got %b expected %b", k, {wr_en, rd_en, busy, done, addr}, {4'b0110, 4'((k / 4) % 16)});
            end
            if (k % 16 == 15) begin
                n_cmp++;
                if (q !== qv) begin
                    n_err++;
                    $display("FAIL restart_q[%0d]: got %h expected %h", k, q, qv);
                end
            end
            step;
        end
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr} !== 8'b0001_0000) begin
            n_err++;
            $display("FAIL restart_done: got %b expected 00010000", {wr_en, rd_en, busy, done, addr});
        end
        step;
    endtask

    task automatic test_midwrite_reset;
        pat_sel = 2'd0;
        seed    = 8'h00;
        wr_flag = 1'b1;
        step;
        wr_flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({wr_en, rd_en, busy, done, addr, wr_data} !== {4'b1010, 4'(i), 8'(i)}) begin
                n_err++;
                $display("FAIL rst_fill[%0d]: got %h expected %h", i, {wr_en, rd_en, busy, done, addr, wr_data}, {4'b1010, 4'(i), 8'(i)});
            end
            if (i < 7) step;
        end
        sys_rst = 1'b1;
        step;
        n_cmp++;
        if ({wr_en, rd_en, busy, done, addr, wr_data} !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_abort: got %h expected 0000", {wr_en, rd_en, busy, done, addr, wr_data});
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step;
            n_cmp++;
            if ({wr_en, rd_en, busy, done, addr, wr_data} !== 16'h0000) begin
                n_err++;
                $display("FAIL rst_no_done[%0d]: got %h expected 0000", i, {wr_en, rd_en, busy, done, addr, wr_data});
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_fill(2'd0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
        test_write_fill(2'd3, 8'hF8, 8'hF8, 8'h01, 1'b0, 1'b1);
        test_write_fill(2'd1, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);
        test_bounded_read(8'hFF, 8'hFF);
        test_read_abort;
        test_write_fill(2'd2, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0);
        test_restart(8'hA5);
        test_midwrite_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
